debug_ocimem_ctrl: RTL and testbench

On-chip debug monitor memory controller for the Nios II debug path, directly downstream of the JTAG debug-slave wrapper. It consumes the wrapper's `jdo` word and `take_action_ocimem_*` strobes in the system-clock domain. It arbitrates a single-port monitor RAM between JTAG host accesses and the CPU's Avalon debug-slave port. It returns read data to the wrapper through `MonDReg`.

---
 rtl/debug_ocimem_pkg.sv | 43 ++++
 rtl/debug_ocimem_ram.sv | 29 ++
 rtl/debug_ocimem_ctrl.sv | 148 ++++++++++++++
 tb/tb_debug_ocimem_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_ocimem_pkg.sv
// Shared types and constants for the debug monitor memory controller:
// FSM states, jdo field positions and JTAG strobe priority.
package debug_ocimem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        J_RD,
        J_CAP,
        J_WR,
        C_ACK
    } state_t;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_MSB  = 17;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    // Numerically larger value wins when several strobes are high together.
    localparam logic [1:0] PRIO_NONE         = 2'd0;
    localparam logic [1:0] PRIO_NO_ACTION_A  = 2'd1;
    localparam logic [1:0] PRIO_ACTION_B     = 2'd2;
    localparam logic [1:0] PRIO_ACTION_A     = 2'd3;

    typedef enum logic [1:0] {
        REQ_NONE    = PRIO_NONE,
        REQ_RD      = PRIO_NO_ACTION_A,
        REQ_WR      = PRIO_ACTION_B,
        REQ_LOAD_RD = PRIO_ACTION_A
    } jreq_t;

    function automatic jreq_t decode_strobe(input logic act_a, input logic act_b,
                                            input logic no_act_a);
        if (act_a)
            return REQ_LOAD_RD;
        else if (act_b)
            return REQ_WR;
        else if (no_act_a)
            return REQ_RD;
        else
            return REQ_NONE;
    endfunction

endpackage

// File: rtl/debug_ocimem_ram.sv
// Single-port DEPTH x 32 monitor RAM, byte-writable, registered read
// (read-first on a simultaneous write).
module debug_ocimem_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // One independent 8-bit lane per byte enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q;

        always_ff @(posedge clk) begin
            if (we && be[gi])
                lane_mem[addr] <= wdata[gi*8 +: 8];
            lane_q <= lane_mem[addr];
        end

        assign rdata[gi*8 +: 8] = lane_q;
    end

endmodule

// File: rtl/debug_ocimem_ctrl.sv
// Debug monitor memory controller: arbitrates the monitor RAM between JTAG
// requests (jdo + strobes) and the CPU Avalon debug-slave port.
module debug_ocimem_ctrl
    import debug_ocimem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [31:0]       mon_d_reg;
    logic [31:0]       wbuf_reg;
    logic [31:0]       readdata_reg;
    logic              pending_reg;
    logic              pend_wr_reg;
    logic              overrun_reg;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    jreq_t             strobe_req;
    logic              strobe_any;
    logic              accept;
    logic              jtag_req;
    logic              jtag_req_wr;
    logic              unused_jdo;

    assign strobe_req  = decode_strobe(take_action_ocimem_a, take_action_ocimem_b,
                                       take_no_action_ocimem_a);
    assign strobe_any  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign accept      = strobe_any && !pending_reg;
    // A strobe accepted this cycle already counts as pending, so IDLE can
    // dispatch it immediately and it wins over a simultaneous CPU request.
    assign jtag_req    = pending_reg || accept;
    assign jtag_req_wr = pending_reg ? pend_wr_reg : (strobe_req == REQ_WR);
    assign unused_jdo  = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        ram_addr   = mon_a_reg;
        ram_we     = 1'b0;
        ram_be     = 4'hF;
        ram_wdata  = wbuf_reg;
        case (state_reg)
            IDLE: begin
                if (jtag_req) begin
                    state_next = jtag_req_wr ? J_WR : J_RD;
                end else if (read || write) begin
                    ram_addr   = address;
                    ram_we     = write && debugaccess;
                    ram_be     = byteenable;
                    ram_wdata  = writedata;
                    state_next = C_ACK;
                end
            end
            J_RD:    state_next = J_CAP;
            J_CAP:   state_next = IDLE;
            J_WR: begin
                ram_we     = 1'b1;
                state_next = IDLE;
            end
            C_ACK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_a_reg    <= '0;
            mon_d_reg    <= '0;
            wbuf_reg     <= '0;
            readdata_reg <= '0;
            pending_reg  <= 1'b0;
            pend_wr_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (strobe_any) begin
                if (pending_reg) begin
                    overrun_reg <= 1'b1;
                end else begin
                    pending_reg <= 1'b1;
                    pend_wr_reg <= (strobe_req == REQ_WR);
                    if (strobe_req == REQ_LOAD_RD)
                        mon_a_reg <= jdo[JDO_ADDR_MSB -: ADDR_W];
                    if (strobe_req == REQ_WR)
                        wbuf_reg <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                end
            end
            // Pending is always high here, so no strobe can load MonAReg this cycle.
            if (state_reg == J_CAP || state_reg == J_WR) begin
                mon_a_reg   <= mon_a_reg + 1'b1;
                pending_reg <= 1'b0;
            end
            if (state_reg == J_CAP)
                mon_d_reg <= ram_rdata;
            if (state_reg == C_ACK)
                readdata_reg <= ram_rdata;
        end
    end

    debug_ocimem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign readdata     = (state_reg == C_ACK) ? ram_rdata : readdata_reg;
    assign waitrequest  = (read || write) && (state_reg != C_ACK);
    assign MonDReg      = mon_d_reg;
    assign jtag_busy    = pending_reg;
    assign jtag_overrun = overrun_reg;

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Self-checking bench for debug_ocimem_ctrl: directed scenarios plus random
// traffic checked against a word-array model of the monitor memory.
module tb_debug_ocimem_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int KA     = 0;   // take_action_ocimem_a
    localparam int KNA    = 1;   // take_no_action_ocimem_a
    localparam int KB     = 2;   // take_action_ocimem_b

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [7:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic        debugaccess = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    always #5 clk = ~clk;

    debug_ocimem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: memory words with per-byte known flags, JTAG registers.
    logic [31:0] mem_m   [DEPTH];
    logic [3:0]  known_m [DEPTH];
    logic [7:0]  mon_a_m;
    logic [31:0] mon_d_m;
    bit          mon_d_known;
    bit          ovr_m;

    function automatic logic [37:0] jdo_addr(input logic [7:0] a);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[17:10] = a;
        return r[37:0];
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[34:3] = d;
        return r[37:0];
    endfunction

    task automatic model_cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem_m[a][b*8 +: 8] = d[b*8 +: 8];
                known_m[a][b] = 1'b1;
            end
        end
    endtask

    task automatic model_jtag(input int kind, input logic [37:0] j);
        if (kind == KA)
            mon_a_m = j[17:10];
        if (kind == KB) begin
            mem_m[mon_a_m]   = j[34:3];
            known_m[mon_a_m] = 4'hF;
        end else begin
            mon_d_m     = mem_m[mon_a_m];
            mon_d_known = (known_m[mon_a_m] == 4'hF);
        end
        mon_a_m = mon_a_m + 8'd1;
    endtask

    task automatic model_reset();
        mon_a_m     = '0;
        mon_d_m     = '0;
        mon_d_known = 1'b1;
        ovr_m       = 1'b0;
    endtask

    task automatic set_strobe(input int kind, input logic v);
        case (kind)
            KA:      take_action_ocimem_a = v;
            KNA:     take_no_action_ocimem_a = v;
            default: take_action_ocimem_b = v;
        endcase
    endtask

    // Entered and left just after a rising edge; counts stall cycles.
    task automatic cpu_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, input bit dbg,
                            output int stalls, output logic [31:0] rd);
        bit done;
        read = !wr; write = wr; address = a; writedata = d;
        byteenable = be; debugaccess = dbg;
        stalls = 0; done = 1'b0; rd = '0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (waitrequest) stalls++;
            else begin done = 1'b1; rd = readdata; end
            @(posedge clk); #1;
        end
        read = 1'b0; write = 1'b0; debugaccess = 1'b0;
        if (wr && dbg) model_cpu_write(a, d, be);
    endtask

    // One-cycle strobe; counts cycles of jtag_busy and samples MonDReg when it drops.
    task automatic jtag_op(input int kind, input logic [37:0] j,
                           output int busy_n, output logic [31:0] md);
        bit done;
        jdo = j; set_strobe(kind, 1'b1);
        @(posedge clk); #1;
        set_strobe(kind, 1'b0);
        busy_n = 0; done = 1'b0; md = '0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (jtag_busy) busy_n++;
            else begin done = 1'b1; md = MonDReg; end
        end
        @(posedge clk); #1;
        model_jtag(kind, j);
    endtask

    // CPU request and JTAG strobe raised in the same cycle.
    task automatic collide(input bit wr, input logic [7:0] a, input logic [31:0] d,
                           input int kind, input logic [37:0] j,
                           output int stalls, output logic [31:0] rd);
        bit done;
        read = !wr; write = wr; address = a; writedata = d;
        byteenable = 4'hF; debugaccess = 1'b1;
        jdo = j; set_strobe(kind, 1'b1);
        stalls = 0; done = 1'b0; rd = '0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (waitrequest) stalls++;
            else begin done = 1'b1; rd = readdata; end
            @(posedge clk); #1;
            set_strobe(kind, 1'b0);
        end
        read = 1'b0; write = 1'b0; debugaccess = 1'b0;
        model_jtag(kind, j);
        if (wr) model_cpu_write(a, d, 4'hF);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL reset_mondreg: got %h expected %h", MonDReg, 32'h0); end
        n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
        n_cmp++; if (waitrequest !== 1'b0) begin n_err++; $display("FAIL reset_waitrequest: got %b expected 0", waitrequest); end
        n_cmp++; if (jtag_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", jtag_busy); end
        n_cmp++; if (jtag_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", jtag_overrun); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_addr_load_read();
        int st, bn;
        logic [31:0] rd, md;
        cpu_xfer(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b1, st, rd);
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL preload_stalls: got %0d expected 1", st); end
        cpu_xfer(1'b1, 8'h06, 32'h0606C0DE, 4'hF, 1'b1, st, rd);
        jtag_op(KA, jdo_addr(8'h05), bn, md);
        $display("jtag load-read addr 05: busy %0d cycles, MonDReg %h", bn, md);
        n_cmp++; if (bn !== 2) begin n_err++; $display("FAIL load_read_busy: got %0d expected 2", bn); end
        n_cmp++; if (md !== mon_d_m) begin n_err++; $display("FAIL load_read_data: got %h expected %h", md, mon_d_m); end
        jtag_op(KNA, jdo_data($urandom()), bn, md);
        $display("jtag read after load: MonDReg %h", md);
        n_cmp++; if (md !== mon_d_m) begin n_err++; $display("FAIL load_read_incr: got %h expected %h", md, mon_d_m); end
    endtask

    task automatic test_wrap();
        int st, bn;
        logic [31:0] rd, md;
        cpu_xfer(1'b1, 8'hFF, 32'hF00DF00D, 4'hF, 1'b1, st, rd);
        jtag_op(KA, jdo_addr(8'hFF), bn, md);
        n_cmp++; if (md !== mon_d_m) begin n_err++; $display("FAIL wrap_read_ff: got %h expected %h", md, mon_d_m); end
        jtag_op(KB, jdo_data(32'h12345678), bn, md);
        $display("jtag write after wrap: busy %0d cycles", bn);
        n_cmp++; if (bn !== 1) begin n_err++; $display("FAIL wrap_write_busy: got %0d expected 1", bn); end
        cpu_xfer(1'b0, 8'h00, 32'h0, 4'hF, 1'b0, st, rd);
        $display("cpu read addr 00: stalls %0d data %h", st, rd);
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL wrap_cpu_stalls: got %0d expected 1", st); end
        n_cmp++; if (rd !== mem_m[0]) begin n_err++; $display("FAIL wrap_cpu_data: got %h expected %h", rd, mem_m[0]); end
    endtask

    task automatic test_byteenable();
        int st;
        logic [31:0] rd;
        cpu_xfer(1'b1, 8'h40, 32'h0, 4'hF, 1'b1, st, rd);
        cpu_xfer(1'b1, 8'h40, 32'hAABBCCDD, 4'b0101, 1'b1, st, rd);
        cpu_xfer(1'b0, 8'h40, 32'h0, 4'hF, 1'b0, st, rd);
        $display("cpu byte-enable write/read: data %h", rd);
        n_cmp++; if (rd !== mem_m[8'h40]) begin n_err++; $display("FAIL be_data: got %h expected %h", rd, mem_m[8'h40]); end
        cpu_xfer(1'b1, 8'h40, 32'h55667788, 4'hF, 1'b0, st, rd);
        $display("cpu write without debugaccess: stalls %0d", st);
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL nodbg_stalls: got %0d expected 1", st); end
        cpu_xfer(1'b0, 8'h40, 32'h0, 4'hF, 1'b0, st, rd);
        n_cmp++; if (rd !== mem_m[8'h40]) begin n_err++; $display("FAIL nodbg_data: got %h expected %h", rd, mem_m[8'h40]); end
    endtask

    task automatic test_collision();
        int st, bn;
        logic [31:0] rd, md;
        cpu_xfer(1'b1, 8'h2F, 32'hA5A50001, 4'hF, 1'b1, st, rd);
        cpu_xfer(1'b1, 8'h30, 32'h11111111, 4'hF, 1'b1, st, rd);
        jtag_op(KA, jdo_addr(8'h2F), bn, md);
        // JTAG read goes first: 1 normal stall plus 3 cycles of delay.
        collide(1'b1, 8'h30, 32'h22222222, KNA, jdo_data($urandom()), st, rd);
        $display("collision cpu write vs jtag read: stalls %0d MonDReg %h", st, MonDReg);
        n_cmp++; if (st !== 4) begin n_err++; $display("FAIL coll_wr_stalls: got %0d expected 4", st); end
        n_cmp++; if (MonDReg !== mon_d_m) begin n_err++; $display("FAIL coll_jtag_first: got %h expected %h", MonDReg, mon_d_m); end
        cpu_xfer(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, st, rd);
        n_cmp++; if (rd !== mem_m[8'h30]) begin n_err++; $display("FAIL coll_cpu_landed: got %h expected %h", rd, mem_m[8'h30]); end
        // JTAG write at 0x31 goes first; the CPU read must see it.
        collide(1'b0, 8'h31, 32'h0, KB, jdo_data(32'h33333333), st, rd);
        $display("collision cpu read vs jtag write: stalls %0d data %h", st, rd);
        n_cmp++; if (st !== 3) begin n_err++; $display("FAIL coll_rd_stalls: got %0d expected 3", st); end
        n_cmp++; if (rd !== mem_m[8'h31]) begin n_err++; $display("FAIL coll_rd_data: got %h expected %h", rd, mem_m[8'h31]); end
    endtask

    task automatic test_overrun();
        int st, bn;
        logic [31:0] rd, md;
        bit done;
        n_cmp++; if (jtag_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_before: got %b expected 0", jtag_overrun); end
        cpu_xfer(1'b1, 8'h50, 32'h50505050, 4'hF, 1'b1, st, rd);
        cpu_xfer(1'b1, 8'h51, 32'h51515151, 4'hF, 1'b1, st, rd);
        cpu_xfer(1'b1, 8'h52, 32'h52525252, 4'hF, 1'b1, st, rd);
        jdo = jdo_addr(8'h50);
        model_jtag(KA, jdo);
        take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        ovr_m = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (!jtag_busy) done = 1'b1;
        end
        @(posedge clk); #1;
        n_cmp++; if (!done) begin n_err++; $display("FAIL ovr_busy_timeout: got busy 1 expected 0"); end
        n_cmp++; if (jtag_overrun !== ovr_m) begin n_err++; $display("FAIL ovr_flag: got %b expected %b", jtag_overrun, ovr_m); end
        n_cmp++; if (MonDReg !== mon_d_m) begin n_err++; $display("FAIL ovr_first_data: got %h expected %h", MonDReg, mon_d_m); end
        jtag_op(KNA, jdo_data($urandom()), bn, md);
        $display("overrun: flag %b, next read MonDReg %h", jtag_overrun, md);
        n_cmp++; if (md !== mon_d_m) begin n_err++; $display("FAIL ovr_single_incr: got %h expected %h", md, mon_d_m); end
    endtask

    task automatic test_reset_mid();
        int st, bn;
        logic [31:0] rd, md;
        jdo = jdo_addr(8'h60);
        take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL rstmid_mondreg: got %h expected %h", MonDReg, 32'h0); end
        n_cmp++; if (jtag_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", jtag_busy); end
        n_cmp++; if (jtag_overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_overrun: got %b expected 0", jtag_overrun); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        jtag_op(KNA, jdo_data($urandom()), bn, md);
        $display("after mid-read reset: busy %0d cycles MonDReg %h", bn, md);
        n_cmp++; if (bn !== 2) begin n_err++; $display("FAIL rstmid_next_busy: got %0d expected 2", bn); end
        n_cmp++; if (md !== mon_d_m) begin n_err++; $display("FAIL rstmid_next_data: got %h expected %h", md, mon_d_m); end
        cpu_xfer(1'b0, 8'h40, 32'h0, 4'hF, 1'b0, st, rd);
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL rstmid_cpu_stalls: got %0d expected 1", st); end
    endtask

    task automatic test_random();
        int st, bn, op;
        logic [31:0] rd, md, d;
        logic [7:0]  a;
        logic [3:0]  be;
        bit          dbg;
        for (int k = 0; k < 16; k++)
            cpu_xfer(1'b1, 8'h80 + 8'(k), $urandom(), 4'hF, 1'b1, st, rd);
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 4);
            a  = 8'h80 + 8'($urandom_range(0, 15));
            case (op)
                0: begin
                    d = $urandom(); be = 4'($urandom_range(0, 15)); dbg = ($urandom_range(0, 3) != 0);
                    cpu_xfer(1'b1, a, d, be, dbg, st, rd);
                    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL rnd_cpu_wr_stalls: got %0d expected 1", st); end
                end
                1: begin
                    cpu_xfer(1'b0, a, 32'h0, 4'hF, 1'b0, st, rd);
                    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL rnd_cpu_rd_stalls: got %0d expected 1", st); end
                    if (known_m[a] == 4'hF) begin
                        n_cmp++; if (rd !== mem_m[a]) begin n_err++; $display("FAIL rnd_cpu_rd_data: addr %h got %h expected %h", a, rd, mem_m[a]); end
                    end
                end
                2, 3: begin
                    if (op == 2 && $urandom_range(0, 9) == 0) a = 8'hFF;
                    jtag_op((op == 2) ? KA : KNA, jdo_addr(a), bn, md);
                    n_cmp++; if (bn !== 2) begin n_err++; $display("FAIL rnd_jtag_rd_busy: got %0d expected 2", bn); end
                    if (mon_d_known) begin
                        n_cmp++; if (md !== mon_d_m) begin n_err++; $display("FAIL rnd_jtag_rd_data: got %h expected %h", md, mon_d_m); end
                    end
                end
                default: begin
                    jtag_op(KB, jdo_data($urandom()), bn, md);
                    n_cmp++; if (bn !== 1) begin n_err++; $display("FAIL rnd_jtag_wr_busy: got %0d expected 1", bn); end
                end
            endcase
        end
        $display("random traffic: 150 operations issued");
        n_cmp++; if (jtag_overrun !== ovr_m) begin n_err++; $display("FAIL rnd_overrun: got %b expected %b", jtag_overrun, ovr_m); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]   = '0;
            known_m[i] = 4'h0;
        end
        model_reset();
        test_reset();
        test_addr_load_read();
        test_wrap();
        test_byteenable();
        test_collision();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
